// File: rtl/mem_stage_pipe.sv
// Purpose: EX->MEM elastic pipeline of DEPTH slots carrying ctrl/operands/rd plus a registered add/sub result.
// Latency: DEPTH cycles from accept to out_valid; one entry per cycle sustained.
// Backpressure: combinational ready chain from out_ready; special_change freezes every slot, flush empties them.
//
// Ports:
//   clk, rest            rising-edge clock, asynchronous active-low reset
//   flush                synchronous kill of every slot (beats special_change)
//   special_change       global freeze: no slot loads or advances, in_ready=0
//   in_valid/in_ready    upstream handshake for ctrl_in/read1_in/aluormem_in/rd_in
//   out_valid/out_ready  downstream handshake for ctrl_out/read1_out/aluormem_out/sum_out/carry_out/ovf_out/rd_out
//   occupancy            registered count of valid slots, 0..DEPTH

module mem_stage_pipe #(
    parameter int DATA_W  = 16,
    parameter int CTRL_W  = 16,
    parameter int RD_W    = 4,
    parameter int DEPTH   = 1,
    parameter int SUB_BIT = 0
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              flush,
    input  logic              special_change,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] read1_in,
    input  logic [DATA_W-1:0] aluormem_in,
    input  logic [RD_W-1:0]   rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] read1_out,
    output logic [DATA_W-1:0] aluormem_out,
    output logic [DATA_W-1:0] sum_out,
    output logic              carry_out,
    output logic              ovf_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [2:0]        occupancy
);

    // One pipeline slot's payload; the valid bit is kept in a separate vector.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] read1;
        logic [DATA_W-1:0] aluormem;
        logic [DATA_W-1:0] sum;
        logic              carry;
        logic              ovf;
        logic [RD_W-1:0]   rd;
    } slot_t;

    // ------------------------------------------------------------------
    // Address adder at the input. Subtract is A + ~B + 1, so carry is the
    // no-borrow flag in subtract mode.
    // ------------------------------------------------------------------
    logic              add_op;
    logic [DATA_W-1:0] add_b_eff;
    logic [DATA_W:0]   add_full;
    logic              add_ovf;
    slot_t             in_slot;

    always_comb begin
        add_op    = ctrl_in[SUB_BIT];
        add_b_eff = add_op ? ~aluormem_in : aluormem_in;
        add_full  = {1'b0, read1_in} + {1'b0, add_b_eff} + {{DATA_W{1'b0}}, add_op};
        // Overflow: both effective operands share a sign that the result lost.
        add_ovf   = (read1_in[DATA_W-1] == add_b_eff[DATA_W-1]) &&
                    (add_full[DATA_W-1] != read1_in[DATA_W-1]);

        in_slot.ctrl     = ctrl_in;
        in_slot.read1    = read1_in;
        in_slot.aluormem = aluormem_in;
        in_slot.sum      = add_full[DATA_W-1:0];
        in_slot.carry    = add_full[DATA_W];
        in_slot.ovf      = add_ovf;
        in_slot.rd       = rd_in;
    end

    // ------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [2:0]       occ_q;
    logic [2:0]       occ_d;

    // feed[k] / feed_vld[k] is what slot k would load: the input for k=0,
    // slot k-1 otherwise. ready[DEPTH] is the downstream ready, so the chain
    // is uniform for every slot including DEPTH=1.
    slot_t            feed [DEPTH+1];
    logic [DEPTH:0]   feed_vld;
    logic [DEPTH:0]   ready;

    always_comb begin
        feed[0]     = in_slot;
        feed_vld[0] = in_valid;
        for (int k = 0; k < DEPTH; k++) begin
            feed[k+1]     = slot_q[k];
            feed_vld[k+1] = vld_q[k];
        end

        // Ready ripples from the output back to the input: a slot can take a
        // new entry if it is empty or its own entry moves on this cycle.
        ready        = '0;
        ready[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            ready[k] = !vld_q[k] || ready[k+1];
        end
    end

    // A flushed input must not look accepted upstream, so flush also gates
    // in_ready in addition to the freeze.
    assign in_ready = ready[0] && !special_change && !flush;

    always_comb begin
        vld_d = vld_q;
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_d[k] = slot_q[k];
            if (ready[k] && !special_change) begin
                vld_d[k] = feed_vld[k];
                // Payload only moves with a valid entry, so the output slot
                // keeps showing the last delivered entry after a drain.
                if (feed_vld[k]) begin
                    slot_d[k] = feed[k];
                end
            end
        end

        if (flush) begin
            vld_d = '0;
        end

        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + 3'(vld_d[k]);
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the last slot.
    // ------------------------------------------------------------------
    assign out_valid    = vld_q[DEPTH-1];
    assign ctrl_out     = slot_q[DEPTH-1].ctrl;
    assign read1_out    = slot_q[DEPTH-1].read1;
    assign aluormem_out = slot_q[DEPTH-1].aluormem;
    assign sum_out      = slot_q[DEPTH-1].sum;
    assign carry_out    = slot_q[DEPTH-1].carry;
    assign ovf_out      = slot_q[DEPTH-1].ovf;
    assign rd_out       = slot_q[DEPTH-1].rd;
    assign occupancy    = occ_q;

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised successor to the single-register EX→MEM stage of the 16-bit pipelined core.
- Carries control word, read operand, ALU/memory value and destination register through DEPTH elastic pipeline slots using a valid/ready handshake.
- Adds a registered address adder with optional subtract mode, carry and signed-overflow flags.
- Adds synchronous flush, a global freeze input and an occupancy count.

Parameters:
- DATA_W, 16, width of operand and result datapath
- CTRL_W, 16, width of control-signal word
- RD_W, 4, width of destination-register index
- DEPTH, 1, number of pipeline slots (1..4)
- SUB_BIT, 0, index in ctrl_in selecting subtract (1) or add (0)

Ports:
- clk  in  1  clock, rising edge
- rest  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all slots
- special_change  in  1  global freeze: no slot loads or advances
- in_valid  in  1  upstream has an entry
- in_ready  out  1  stage accepts an entry this cycle
- ctrl_in  in  CTRL_W  control signals
- read1_in  in  DATA_W  operand A
- aluormem_in  in  DATA_W  operand B
- rd_in  in  RD_W  destination register
- out_valid  out  1  last slot holds valid entry
- out_ready  in  1  downstream accepts
- ctrl_out  out  CTRL_W  registered control word
- read1_out  out  DATA_W  registered operand A
- aluormem_out  out  DATA_W  registered operand B
- sum_out  out  DATA_W  registered A+B or A−B
- carry_out  out  1  carry (add) / no-borrow (sub)
- ovf_out  out  1  two's-complement overflow
- rd_out  out  RD_W  registered destination
- occupancy  out  3  count of valid slots, 0..DEPTH

Behaviour:
- Reset (rest=0, async): all slot valid bits=0; all data fields, sum_out, carry_out, ovf_out=0; occupancy=0; out_valid=0. in_ready is 1 once rest=1.
- Adder, combinational at input:
  - op = ctrl_in[SUB_BIT].
  - {carry, sum} = A + (op ? ~B : B) + op, computed in DATA_W+1 bits.
  - ovf = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is the effective (inverted-if-sub) operand.
  - Results are captured into slot 0 together with the other fields.
- Slots 0..DEPTH−1; slot DEPTH−1 drives the outputs.
- Combinational ready chain: ready[DEPTH−1] = !valid[DEPTH−1] || out_ready; ready[k] = !valid[k] || ready[k+1]. in_ready = ready[0] && !special_change.
- Slot k loads from its predecessor (or input for k=0) when ready[k] && !special_change. Its valid bit takes the predecessor's valid (in_valid for k=0).
- Latency: an accepted entry reaches out_valid after DEPTH cycles with no backpressure. Throughput is 1/cycle.
- Full-throughput pass-through: when all slots are valid and out_ready=1, every slot advances the same cycle.
- special_change=1:
  - All slots hold their contents.
  - in_ready=0.
  - out_valid unchanged. Downstream must not count a transfer while frozen, and transfer = out_valid && out_ready && !special_change.
- flush=1 (sync): next edge clears every valid bit, occupancy=0, and the input is not accepted. Data fields may retain stale values. flush overrides special_change.
- Data fields of invalid slots need not update, but outputs must hold the last value when out_valid=0 after a drain.
- occupancy: registered popcount of valid bits; updated the same edge as the valid bits.
- Wrap/width: sum truncated to DATA_W. Carry reflects bit DATA_W. No saturation.
- Reset mid-transfer: all entries are discarded immediately. No partial output.

Test Plan:
1. Reset, then DEPTH=1: push A=0x0003, B=0x0004, ctrl=0x0000, rd=5 → next cycle out_valid=1, sum_out=0x0007, carry=0, ovf=0, rd_out=5.
2. Add overflow, A=0x7FFF, B=0x0001 → sum_out=0x8000, ovf=1, carry=0. Add wrap, A=0xFFFF, B=0x0001 → sum_out=0x0000, carry=1, ovf=0.
3. Subtract, ctrl[0]=1, A=0x0005, B=0x0007 → sum_out=0xFFFE, carry=0, ovf=0. A=0x8000, B=0x0001 → sum_out=0x7FFF, ovf=1, carry=1.
4. DEPTH=3, stream 5 entries with out_ready=0 → in_ready drops after 3 accepts, occupancy=3. Raise out_ready → entries exit in order, one per cycle.
5. special_change=1 for 2 cycles mid-stream with in_valid=1 → no accept, outputs and occupancy frozen. Release → stream resumes with no loss or duplication.
6. flush with occupancy=2, in_valid=1 → next cycle out_valid=0, occupancy=0, flushed input not accepted. Also assert rest=0 mid-stream → outputs zero immediately, without a clock edge.
